// File: rtl/ps2_serial_rx.sv
// PS/2 keyboard receiver: synchronises and filters the raw PS/2 lines,
// deframes bytes, strips E0/F0/E1 prefixes and emits toggle-strobed key events.
//
// Ports:
//   clk_sys      system clock (only clock)
//   reset_n      asynchronous active-low reset
//   ps2_clk_in   raw PS/2 clock line (asynchronous)
//   ps2_data_in  raw PS/2 data line (asynchronous)
//   ps2_key      [7:0] code, [8] extended, [9] pressed, [10] toggles per event
//   rx_byte      last correctly framed byte
//   rx_strobe    one-cycle pulse when rx_byte updates
//   frame_err    one-cycle pulse on parity, stop or timeout error
module ps2_serial_rx #(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 100000
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ps2_clk_in,
    input  logic        ps2_data_in,
    output logic [10:0] ps2_key,
    output logic [7:0]  rx_byte,
    output logic        rx_strobe,
    output logic        frame_err
);

    localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [FW-1:0] FMAX = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } state_t;

    logic [1:0]    clk_sync;
    logic [1:0]    data_sync;
    logic [FW-1:0] filt_cnt;
    logic          clk_filt;
    logic          clk_filt_d;
    logic          bit_evt;
    logic          din;

    state_t        state;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;
    logic          par;
    logic [TW-1:0] tcnt;
    logic          timeout_hit;
    logic          frame_ok;

    logic          ext;
    logic          rel;
    logic [2:0]    skip;
    logic          is_resp;

    // Lines idle high, so synchronisers and filter reset to 1.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            clk_sync   <= 2'b11;
            data_sync  <= 2'b11;
            filt_cnt   <= '0;
            clk_filt   <= 1'b1;
            clk_filt_d <= 1'b1;
        end else begin
            clk_sync   <= {clk_sync[0], ps2_clk_in};
            data_sync  <= {data_sync[0], ps2_data_in};
            clk_filt_d <= clk_filt;
            // Count consecutive samples that disagree with the filtered level.
            if (clk_sync[1] == clk_filt) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FMAX) begin
                clk_filt <= clk_sync[1];
                filt_cnt <= '0;
            end else begin
                filt_cnt <= filt_cnt + 1'b1;
            end
        end
    end

    assign bit_evt     = clk_filt_d & ~clk_filt;
    assign din         = data_sync[1];
    assign timeout_hit = (state != IDLE) && !bit_evt && (tcnt == TMAX);
    // Odd parity over the eight data bits plus the parity bit.
    assign frame_ok    = din && (^{shift, par});
    assign is_resp     = rx_byte inside {8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF};

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shift     <= '0;
            par       <= 1'b0;
            tcnt      <= '0;
            rx_byte   <= '0;
            rx_strobe <= 1'b0;
            frame_err <= 1'b0;
            ps2_key   <= '0;
            ext       <= 1'b0;
            rel       <= 1'b0;
            skip      <= '0;
        end else begin
            rx_strobe <= 1'b0;
            frame_err <= 1'b0;

            if (bit_evt || state == IDLE) begin
                tcnt <= '0;
            end else begin
                tcnt <= tcnt + 1'b1;
            end

            // Prefix decoder acts on the byte strobed last cycle.
            if (rx_strobe) begin
                priority case (1'b1)
                    (skip != 3'd0): skip <= skip - 3'd1;
                    (rx_byte == 8'hE1): skip <= 3'd7;
                    (rx_byte == 8'hE0): ext <= 1'b1;
                    (rx_byte == 8'hF0): rel <= 1'b1;
                    (is_resp && !ext && !rel): ;
                    default: begin
                        ps2_key <= {~ps2_key[10], ~rel, ext, rx_byte};
                        ext     <= 1'b0;
                        rel     <= 1'b0;
                    end
                endcase
            end

            // Errors come last so their flag clearing wins.
            if (timeout_hit) begin
                state     <= IDLE;
                frame_err <= 1'b1;
                ext       <= 1'b0;
                rel       <= 1'b0;
                skip      <= '0;
            end else if (bit_evt) begin
                unique case (state)
                    IDLE: begin
                        if (!din) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end
                    end
                    DATA: begin
                        shift   <= {din, shift[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state <= PARITY;
                        end
                    end
                    PARITY: begin
                        par   <= din;
                        state <= STOP;
                    end
                    STOP: begin
                        state <= IDLE;
                        if (frame_ok) begin
                            rx_byte   <= shift;
                            rx_strobe <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                            ext       <= 1'b0;
                            rel       <= 1'b0;
                            skip      <= '0;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_serial_rx.sv
// Scoreboard bench for ps2_serial_rx: directed PS/2 frames plus random
// traffic, checked against a byte-level reference model.
module tb_ps2_serial_rx;

    localparam int FL = 8;
    localparam int TO = 2000;
    localparam int HP = 20;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        ps2_clk_in = 1'b1;
    logic        ps2_data_in = 1'b1;
    logic [10:0] ps2_key;
    logic [7:0]  rx_byte;
    logic        rx_strobe;
    logic        frame_err;

    ps2_serial_rx #(
        .FILTER_LEN(FL),
        .TIMEOUT   (TO)
    ) dut (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .ps2_clk_in (ps2_clk_in),
        .ps2_data_in(ps2_data_in),
        .ps2_key    (ps2_key),
        .rx_byte    (rx_byte),
        .rx_strobe  (rx_strobe),
        .frame_err  (frame_err)
    );

    always #5 clk_sys = ~clk_sys;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int err_cyc = 0;

    always @(posedge clk_sys) cyc <= cyc + 1;

    // Expected strobe/error events: {err, byte}.
    logic [8:0]  ev_q[$];
    logic [10:0] key_q[$];

    // Reference model state.
    bit          m_ext;
    bit          m_rel;
    int          m_skip;
    logic [10:0] m_key;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic model_reset();
        m_ext  = 0;
        m_rel  = 0;
        m_skip = 0;
        m_key  = '0;
    endtask

    task automatic model_frame(input logic [7:0] b, input bit bad);
        if (bad) begin
            ev_q.push_back({1'b1, 8'h00});
            m_ext  = 0;
            m_rel  = 0;
            m_skip = 0;
        end else begin
            ev_q.push_back({1'b0, b});
            if (m_skip > 0) m_skip--;
            else if (b == 8'hE1) m_skip = 7;
            else if (b == 8'hE0) m_ext = 1;
            else if (b == 8'hF0) m_rel = 1;
            else if (!m_ext && !m_rel &&
                     (b == 8'hFA || b == 8'hAA || b == 8'hEE ||
                      b == 8'hFE || b == 8'h00 || b == 8'hFF)) begin
            end else begin
                m_key = {~m_key[10], ~m_rel, m_ext, b};
                key_q.push_back(m_key);
                m_ext = 0;
                m_rel = 0;
            end
        end
    endtask

    task automatic send_bit(input bit d, input bit glitch);
        ps2_data_in = d;
        if (glitch) begin
            tick(2);
            ps2_clk_in = 1'b0;
            tick(FL - 1);
            ps2_clk_in = 1'b1;
        end
        tick(HP / 2);
        ps2_clk_in = 1'b0;
        tick(HP);
        ps2_clk_in = 1'b1;
        tick(HP / 2);
    endtask

    task automatic send_raw(input logic [7:0] b, input bit bad_par,
                            input bit bad_stop, input bit glitch);
        bit p;
        p = ~(^b) ^ bad_par;
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i], glitch && (i == 3));
        send_bit(p, 1'b0);
        send_bit(~bad_stop, 1'b0);
        ps2_data_in = 1'b1;
    endtask

    task automatic frame(input logic [7:0] b);
        model_frame(b, 1'b0);
        send_raw(b, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((ev_q.size() != 0 || key_q.size() != 0) && n < budget) begin
            tick(1);
            n++;
        end
        tick(4);
        checks++;
        if (ev_q.size() != 0 || key_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending ev %0d key %0d want 0 0",
                     ev_q.size(), key_q.size());
            ev_q.delete();
            key_q.delete();
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        @(negedge clk_sys);
        chk({tag, "_key"}, 32'(ps2_key), 32'h0);
        chk({tag, "_byte"}, 32'(rx_byte), 32'h0);
        chk({tag, "_strobe"}, 32'(rx_strobe), 32'h0);
        chk({tag, "_err"}, 32'(frame_err), 32'h0);
    endtask

    // Monitor: pops expectations whenever the DUT presents an output.
    logic [10:0] prev_key = '0;
    bit          prev_strobe = 0;

    always @(negedge clk_sys) begin
        if (!reset_n) begin
            prev_key    = ps2_key;
            prev_strobe = 0;
        end else begin
            if (rx_strobe && frame_err) chk("strobe_and_err", 32'h1, 32'h0);
            if (frame_err) err_cyc = cyc;
            if (rx_strobe || frame_err) begin
                if (ev_q.size() == 0) begin
                    chk("unexpected_event", {23'h0, frame_err, rx_byte},
                        32'h1ff);
                end else begin
                    chk("event", {23'h0, frame_err,
                                  frame_err ? 8'h00 : rx_byte},
                        32'(ev_q.pop_front()));
                end
            end
            if (ps2_key != prev_key) begin
                chk("key_latency", 32'(prev_strobe), 32'h1);
                if (key_q.size() == 0)
                    chk("unexpected_key", 32'(ps2_key), 32'(prev_key));
                else
                    chk("key", 32'(ps2_key), 32'(key_q.pop_front()));
            end
            prev_key    = ps2_key;
            prev_strobe = rx_strobe;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog timeout got running want finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] pause_seq[8];
        logic [7:0] resp[6];
        int fall_cyc;
        int lat;
        pause_seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
        resp = '{8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF};
        model_reset();

        tick(3);
        check_outputs_zero("reset");
        reset_n = 1'b1;
        tick(5);

        frame(8'h1C);
        frame(8'hF0);
        frame(8'h1C);
        frame(8'hE0);
        frame(8'h75);
        frame(8'hE0);
        frame(8'hF0);
        frame(8'h75);

        model_frame(8'h1C, 1'b1);
        send_raw(8'h1C, 1'b1, 1'b0, 1'b0);
        frame(8'hE0);
        frame(8'h6B);

        frame(8'hF0);
        model_frame(8'h33, 1'b1);
        send_raw(8'h33, 1'b0, 1'b1, 1'b0);
        frame(8'h1C);
        drain(500);

        // Partial frame after E0, then the clock stays high.
        frame(8'hE0);
        drain(500);
        model_frame(8'h00, 1'b1);
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'($urandom_range(0, 1)), 1'b0);
        ps2_data_in = 1'($urandom_range(0, 1));
        tick(HP / 2);
        ps2_clk_in = 1'b0;
        fall_cyc = cyc;
        tick(HP);
        ps2_clk_in = 1'b1;
        ps2_data_in = 1'b1;
        tick(TO + 60);
        lat = err_cyc - fall_cyc;
        chk("timeout_window", 32'((lat >= TO) && (lat <= TO + 20)), 32'h1);
        frame(8'h29);

        foreach (pause_seq[i]) frame(pause_seq[i]);
        frame(8'h1C);
        frame(8'hAA);

        model_frame(8'h5A, 1'b0);
        send_raw(8'h5A, 1'b0, 1'b0, 1'b1);
        model_frame(8'hC3, 1'b0);
        send_raw(8'hC3, 1'b0, 1'b0, 1'b1);
        drain(500);

        // Reset in the middle of a frame.
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        reset_n = 1'b0;
        ps2_clk_in = 1'b1;
        ps2_data_in = 1'b1;
        model_reset();
        check_outputs_zero("midreset");
        tick(5);
        reset_n = 1'b1;
        tick(5);
        frame(8'h1C);

        for (int n = 0; n < 40; n++) begin
            logic [7:0] b;
            int sel;
            int e;
            sel = $urandom_range(0, 19);
            if (sel < 3) b = 8'hE0;
            else if (sel < 6) b = 8'hF0;
            else if (sel == 6) b = 8'hE1;
            else if (sel < 9) b = resp[$urandom_range(0, 5)];
            else b = 8'($urandom_range(0, 255));
            e = $urandom_range(0, 9);
            if (e == 0) begin
                model_frame(b, 1'b1);
                send_raw(b, 1'b1, 1'b0, 1'b0);
            end else if (e == 1) begin
                model_frame(b, 1'b1);
                send_raw(b, 1'b0, 1'b1, 1'b0);
            end else begin
                model_frame(b, 1'b0);
                send_raw(b, 1'b0, 1'b0, $urandom_range(0, 3) == 0);
            end
        end
        drain(2000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_serial_rx.md
Name: ps2_serial_rx

Overview:
- Device-side PS/2 keyboard receiver. Deserialises the raw PS/2 clock/data lines and strips the E0/F0/E1 prefixes.
- Emits the 11-bit toggle-strobed key event bus that the keyboard matrix mapper consumes: [7:0] scancode, [8] extended, [9] pressed, [10] toggles per event.
- Sits between the PS/2 pins (or a pin-level mux) and the keyboard/matrix block, all in the clk_sys domain.

Parameters:
- FILTER_LEN, 8: consecutive equal synchronised samples required before the filtered ps2_clk changes state (range 2..32).
- TIMEOUT, 100000: clk_sys cycles allowed between bit edges inside a frame before the frame is abandoned (about 2 ms at 50 MHz).

Ports:
- clk_sys  in  1  system clock; only clock.
- reset_n  in  1  asynchronous, active-low reset.
- ps2_clk_in  in  1  raw PS/2 clock line, asynchronous.
- ps2_data_in  in  1  raw PS/2 data line, asynchronous.
- ps2_key  out  11  key event bus: [7:0] code, [8] extended, [9] pressed, [10] toggle.
- rx_byte  out  8  last correctly framed byte, raw.
- rx_strobe  out  1  one-cycle pulse when rx_byte updates.
- frame_err  out  1  one-cycle pulse on parity, stop or timeout error.

Behaviour:
- Reset: ps2_key=0, rx_byte=0, rx_strobe=0, frame_err=0, FSM=IDLE, ext/rel/skip state cleared, filter output=1. Reset may assert at any time and aborts any frame immediately.
- Input conditioning:
  - 2-FF synchroniser on both lines.
  - ps2_clk filter: the filtered value flips only after FILTER_LEN consecutive samples differ from it.
  - Bit event = filtered clock 1->0. Data is sampled from the synchronised data line in the same cycle.
- Frame FSM, driven on bit events:
  - IDLE: data=0 -> DATA with bit count 0. Data=1 -> stay IDLE (spurious edge), no error.
  - DATA: shift LSB first. After the 8th bit -> PARITY.
  - PARITY: store the bit -> STOP.
  - STOP: valid when stop=1 AND the data bits plus parity have an odd count of ones.
    - Valid: rx_byte loads and rx_strobe pulses in the cycle after the stop bit event.
    - Invalid: frame_err pulses in that cycle instead. Either way -> IDLE.
- Timeout:
  - Counter clears on every bit event and counts in any non-IDLE state.
  - Reaching TIMEOUT-1: FSM -> IDLE, frame_err pulses, ext/rel/skip cleared.
  - Never counts in IDLE.
- Any frame error also clears ext, rel and skip.
- Prefix decoder, acts on rx_strobe, same cycle:
  - skip>0: decrement skip, no event.
  - Byte E1: skip=7, covering the pause sequence E1 14 77 E1 F0 14 F0 77. No event.
  - Byte E0: ext=1. Byte F0: rel=1.
  - Bytes FA, AA, EE, FE, 00, FF with ext=0 and rel=0: dropped as device responses; flags unchanged.
  - Any other byte: in the next cycle ps2_key <= {~ps2_key[10], ~rel, ext, byte}, and ext and rel clear.
- Latency: ps2_key updates exactly 2 clk_sys cycles after the stop-bit event. Bits [9:0] are stable whenever bit 10 changes.
- E0 12 / E0 F0 12 (fake shift) are forwarded unfiltered as extended code 12; the consumer handles them.
- Back-to-back frames need no idle gap beyond the filter. A new start bit is accepted on the first bit event after STOP.
- rx_strobe and frame_err are never asserted in the same cycle.

Test Plan:
- Frame 1C (start 0, bits LSB first, parity 0, stop 1) after reset -> rx_strobe pulses, rx_byte=1C. Two cycles after the stop bit ps2_key=11'h61C.
- Then frames F0, 1C -> ps2_key=11'h01C (toggle 0, pressed 0). Then E0, 75 -> 11'h775. Then E0, F0, 75 -> 11'h175.
- Frame 1C with parity bit 1 -> frame_err pulses once, rx_strobe stays 0, ps2_key unchanged. A following E0 then 6B gives an extended event (ext was not latched from the bad frame).
- Start bit plus 4 data bits, then clock held high for TIMEOUT cycles -> frame_err pulses at count TIMEOUT-1, FSM IDLE. A next full frame 29 is decoded to ps2_key[7:0]=29.
- Pause sequence E1 14 77 E1 F0 14 F0 77, then 1C -> no ps2_key change during the 8 bytes; bit 10 toggles only for 1C. Frame AA alone -> rx_strobe pulses, ps2_key unchanged.
- ps2_clk low glitches of FILTER_LEN-1 cycles mid-frame -> no extra bits shifted, correct byte received. Assert reset_n=0 mid-frame -> all outputs 0 next edge; first post-reset frame decodes correctly.
